// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: turns a length-prefixed big-endian byte
// stream into 32-bit word writes and holds the core in reset until the image is in.
module imem_loader #(
  parameter logic [31:0] BOOT_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             reload,
  output logic             mem_wen,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_data,
  output logic             core_rst,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t           r_state;
  logic [1:0]       r_lane;
  logic [CNT_W-1:0] r_len;
  logic [23:0]      r_asm;

  logic             w_accept;
  logic [CNT_W-1:0] w_len;
  logic             w_last;

  // reload gates ready so a colliding byte is never consumed
  assign in_ready = !reload && ((r_state == S_HDR0) || (r_state == S_HDR1) ||
                                (r_state == S_DATA));
  assign w_accept = in_valid && in_ready;
  assign w_len    = r_len | CNT_W'(in_data);
  assign w_last   = (words_loaded + CNT_W'(1)) == r_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_HDR0;
      r_lane       <= 2'd0;
      r_len        <= '0;
      r_asm        <= 24'd0;
      mem_wen      <= 1'b0;
      mem_addr     <= BOOT_ADDR;
      mem_data     <= 32'd0;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else if (reload) begin
      r_state      <= S_HDR0;
      r_lane       <= 2'd0;
      r_len        <= '0;
      mem_wen      <= 1'b0;
      mem_addr     <= BOOT_ADDR;
      core_rst     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_wen <= 1'b0;
      case (r_state)
        S_HDR0: begin
          if (w_accept) begin
            r_len   <= CNT_W'({in_data, 8'h00});
            r_state <= S_HDR1;
          end
        end
        S_HDR1: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len == '0) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else if (32'(w_len) > MAX_WORDS) begin
              r_state <= S_ERR;
              err     <= 1'b1;
            end else begin
              r_state <= S_DATA;
              r_lane  <= 2'd0;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_lane <= r_lane + 2'd1;
            r_asm  <= {r_asm[15:0], in_data};
            if (r_lane == 2'd3) begin
              mem_wen  <= 1'b1;
              mem_data <= {r_asm, in_data};
            end
          end
          // mem_addr tracks BOOT_ADDR + 4*words_loaded; both advance as the strobe falls
          if (mem_wen) begin
            words_loaded <= words_loaded + CNT_W'(1);
            mem_addr     <= mem_addr + 32'd4;
            if (w_last) begin
              r_state  <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader: the write side of the core's instruction memory. The core fetches from that memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit words and writes them through a single write port starting at BOOT_ADDR.
- Holds the core in reset until the whole image is written, then releases it. Replaces the simulation-only hex preload.

Parameters:
- BOOT_ADDR, 32'd0, byte address of the first word written; must match the core's BOOT_ADDR.
- MAX_WORDS, 256, capacity of the target memory in words; a larger header length is an error.
- CNT_W, 16, width of the header length field and of the word counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader can accept a byte this cycle.
- reload  input  1  synchronous restart request, sampled on clk.
- mem_wen  output  1  write strobe to instruction memory, one cycle per word.
- mem_addr  output  32  byte address of the word being written.
- mem_data  output  32  word being written.
- core_rst  output  1  active-high reset to the core.
- done  output  1  image fully written, core released.
- err  output  1  header length exceeded MAX_WORDS.
- words_loaded  output  CNT_W  number of words written so far.

Behaviour:
- Reset (async, rst=1), all outputs registered:
  - state=HDR0, core_rst=1, mem_wen=0, mem_addr=BOOT_ADDR, mem_data=0, done=0, err=0, words_loaded=0.
  - Byte-lane counter=0, length register=0.
- Handshake:
  - A byte transfers on a rising edge where in_valid&&in_ready.
  - in_ready=1 only in states HDR0, HDR1 and DATA, and only when reload=0.
  - in_valid may toggle freely; bytes with in_ready=0 are not consumed.
- Stream format: 2-byte length L (words, MSB first), then 4*L data bytes, each word MSB first (MIPS big-endian). Only the low CNT_W bits of the 16-bit header are kept.
- HDR0: accept length[15:8] -> HDR1.
- HDR1: accept length[7:0], then:
  - L==0 -> DONE.
  - L>MAX_WORDS -> ERR.
  - Otherwise -> DATA.
- DATA:
  - Each accepted byte shifts into a 32-bit assembly register (new byte into [7:0], previous bytes move up); the lane counter increments 0..3.
  - On the 4th byte (lane 3), the lane counter wraps to 0.
  - The next cycle carries a one-cycle write: mem_wen=1, mem_data=assembled word, mem_addr=BOOT_ADDR+4*words_loaded.
  - words_loaded increments on the same edge that drops mem_wen.
  - Back-to-back words need no gap: a byte may be accepted during the mem_wen cycle.
  - After the write of word L-1 (edge where mem_wen falls) -> DONE.
- DONE: core_rst=0 and done=1 from that edge onward; in_ready=0; no further writes.
- ERR: err=1, core_rst stays 1, in_ready=0, no writes. Exit only by reload or rst.
- reload=1 on any edge, any state:
  - state=HDR0, core_rst=1, done=0, err=0, words_loaded=0, lane=0, mem_wen=0 next cycle, mem_addr=BOOT_ADDR.
  - reload takes priority over a simultaneous byte, which is not consumed (in_ready is already 0).
- mem_addr arithmetic is 32-bit modulo, with no address wrap check beyond MAX_WORDS.
- Async rst mid-load aborts immediately. Partially written memory is left as is; core_rst=1.
- mem_wen is never high in HDR0, HDR1, DONE or ERR, except for the final-word pulse that completes as DATA exits.

Test Plan:
- Stream 00 02 | 24 08 00 05 | 01 09 50 20 with in_valid held high -> two mem_wen pulses, (addr 0x0, data 0x24080005) then (addr 0x4, data 0x01095020); done=1 and core_rst=0 one cycle after the second pulse; words_loaded=2.
- Same stream with in_valid deasserted every other cycle -> identical writes and data, only later; no byte lost or duplicated.
- Header 00 00 -> no mem_wen; done=1 and core_rst=0 on the edge after the second header byte.
- Header 01 01 (L=257 > MAX_WORDS=256) -> err=1, in_ready=0, core_rst=1, no writes; then pulse reload -> err=0, HDR0, in_ready=1.
- Mid-word (after 2 data bytes of word 1), assert reload together with in_valid -> that byte not consumed; words_loaded=0, mem_addr=BOOT_ADDR; a fresh stream 00 01 AA BB CC DD writes 0xAABBCCDD at BOOT_ADDR.
- Assert rst asynchronously mid-DATA (between clock edges) -> outputs immediately at reset values (core_rst=1, mem_wen=0, done=0); BOOT_ADDR=0x100 build writes its first word at 0x100.
